uart_tx: RTL and testbench

Serial transmitter and the outbound counterpart of the team's UART receive path. It accepts a parallel byte over a one-cycle start handshake, then drives a framed asynchronous serial stream on `serial_out`. The frame is a start bit, DATA_BITS data bits sent LSB first, an optional parity bit and a stop bit. Each bit is held for CLKS_PER_BIT clocks, which matches the receiver's bit-period timing.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/flex_counter.sv | 54 +++++
 rtl/uart_tx.sv | 168 ++++++++++++++++
 tb/tb_uart_tx.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Definitions shared by the UART transmit and receive paths.
//               Contains the frame state encoding and the line levels for
//               idle and start.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/flex_counter.sv
`default_nettype none
// ============================================================================
// Module      : flex_counter
// Description : Programmable rollover counter. It counts 1..rollover_val
//               while enabled and then wraps back to 1. clear forces the count
//               to 0 and takes priority over count_enable.
//               rollover_flag is high in the cycle whose clock edge loads
//               rollover_val into the count.
// Ports       : clk           - rising-edge clock
//               n_rst         - asynchronous active-low reset
//               clear         - synchronous clear to 0
//               count_enable  - advance the count this cycle
//               rollover_val  - terminal count value
//               rollover_flag - strobe, one cycle per rollover period
// Revision    : 1.0 - initial release
// ============================================================================
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic                    rollover_flag
);

  logic [NUM_CNT_BITS-1:0] count;
  logic [NUM_CNT_BITS-1:0] count_next;

  always_comb begin
    if (count == rollover_val) begin
      count_next = NUM_CNT_BITS'(1);
    end else begin
      count_next = count + NUM_CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_enable) begin
      count <= count_next;
    end
  end

  // Flag the cycle that completes a full period. The period then ends on the
  // same edge that loads rollover_val, so the user advances in step.
  assign rollover_flag = count_enable && !clear && (count_next == rollover_val);

endmodule : flex_counter
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : UART serial transmitter. It accepts a word on tx_start while
//               idle and sends start bit, DATA_BITS data bits LSB first, an
//               optional even-parity bit and a stop bit. Each bit is held for
//               CLKS_PER_BIT clocks. All outputs are registered.
// Config      : define UART_TX_PARITY_EN to insert the even-parity bit.
// Ports       : clk        - rising-edge clock
//               n_rst      - asynchronous active-low reset
//               tx_data    - word to send, sampled on accepted tx_start
//               tx_start   - send request, ignored while tx_busy
//               serial_out - serial line, idle high
//               tx_busy    - frame in progress
//               tx_done    - one-cycle pulse after the stop bit
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_start,
  output logic                 serial_out,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int BIT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] PERIOD   = CNT_W'(CLKS_PER_BIT);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  uart_state_e          state;
  uart_state_e          state_next;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] shift_next;
  logic [BIT_W-1:0]     bit_cnt;
  logic [BIT_W-1:0]     bit_cnt_next;
  logic                 serial_next;
  logic                 done_next;
  logic                 bit_strobe;
  logic                 cnt_clear;
  logic                 cnt_enable;
`ifdef UART_TX_PARITY_EN
  logic                 parity_bit;
  logic                 parity_next;
`endif

  assign cnt_clear  = (state == IDLE);
  assign cnt_enable = (state != IDLE);

  flex_counter #(
    .NUM_CNT_BITS (CNT_W)
  ) u_period_cnt (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (cnt_clear),
    .count_enable  (cnt_enable),
    .rollover_val  (PERIOD),
    .rollover_flag (bit_strobe)
  );

  // Next-state, datapath and output decode. Outputs are computed from the
  // next state so that they can be registered without adding a cycle of
  // latency to the line.
  always_comb begin
    state_next   = state;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt;
    done_next    = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_next  = parity_bit;
`endif

    case (state)
      IDLE: begin
        if (tx_start) begin
          state_next = START;
          shift_next = tx_data;
`ifdef UART_TX_PARITY_EN
          // Parity is taken now because the shift register is consumed.
          parity_next = ^tx_data;
`endif
        end
      end
      START: begin
        if (bit_strobe) begin
          state_next = DATA;
        end
      end
      DATA: begin
        if (bit_strobe) begin
          shift_next = shift_reg >> 1;
          if (bit_cnt == LAST_BIT) begin
            bit_cnt_next = '0;
`ifdef UART_TX_PARITY_EN
            state_next   = PARITY;
`else
            state_next   = STOP;
`endif
          end else begin
            bit_cnt_next = bit_cnt + BIT_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_strobe) begin
          state_next = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_strobe) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    case (state_next)
      START:   serial_next = UART_START_LEVEL;
      DATA:    serial_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  serial_next = parity_next;
`endif
      default: serial_next = UART_IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      serial_out <= UART_IDLE_LEVEL;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      state      <= state_next;
      shift_reg  <= shift_next;
      bit_cnt    <= bit_cnt_next;
      serial_out <= serial_next;
      tx_busy    <= (state_next != IDLE);
      tx_done    <= done_next;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      parity_bit <= 1'b0;
    end else begin
      parity_bit <= parity_next;
    end
  end
`endif

endmodule : uart_tx
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx
// Description : Self-checking bench for uart_tx. Accepted frames are queued
//               with their start cycle; a monitor derives the expected line,
//               busy and done levels for every cycle from the frame layout.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

  localparam int C = 10;
  localparam int D = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = D + 3;
`else
  localparam int NBITS = D + 2;
`endif
  localparam int L = C * NBITS;

  typedef struct {
    int           s;
    logic [D-1:0] data;
  } frame_t;

  logic         clk;
  logic         n_rst;
  logic [D-1:0] tx_data;
  logic         tx_start;
  logic         serial_out;
  logic         tx_busy;
  logic         tx_done;

  int     cyc;
  int     checks;
  int     fails;
  frame_t q[$];

  uart_tx #(
    .CLKS_PER_BIT (C),
    .DATA_BITS    (D)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .serial_out (serial_out),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp);
    end
  endtask

  // Expected line level r cycles after the acceptance cycle (1 <= r <= L).
  function automatic logic exp_line(input int r, input logic [D-1:0] data);
    int idx;
    if (r <= C) return 1'b0;
    if (r <= C * (D + 1)) begin
      idx = (r - 1) / C - 1;
      return data[idx];
    end
`ifdef UART_TX_PARITY_EN
    if (r <= C * (D + 2)) return ^data;
`endif
    return 1'b1;
  endfunction

  function automatic bit model_busy(input int n);
    foreach (q[k]) begin
      if ((n - q[k].s) >= 1 && (n - q[k].s) <= L) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Drive one cycle of stimulus; the model decides whether it is accepted.
  task automatic drive(input logic start, input logic [D-1:0] data);
    frame_t f;
    @(negedge clk);
    tx_start = start;
    tx_data  = data;
    if (start && n_rst && !model_busy(cyc)) begin
      f.s    = cyc;
      f.data = data;
      q.push_back(f);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) drive(1'b0, D'($urandom));
  endtask

  // Monitor: compare every cycle against the frame at the head of the queue.
  always begin
    int   r;
    logic e_line;
    logic e_busy;
    logic e_done;
    @(posedge clk);
    #1;
    while (q.size() > 0 && cyc > q[0].s + L + 1) void'(q.pop_front());
    e_line = 1'b1;
    e_busy = 1'b0;
    e_done = 1'b0;
    if (q.size() > 0) begin
      r = cyc - q[0].s;
      if (r >= 1 && r <= L) begin
        e_line = exp_line(r, q[0].data);
        e_busy = 1'b1;
      end else if (r == L + 1) begin
        e_done = 1'b1;
      end
    end
    check("serial_out", serial_out, e_line);
    check("tx_busy", tx_busy, e_busy);
    check("tx_done", tx_done, e_done);
  end

  initial begin
    int s1;
    int s2;
    checks   = 0;
    fails    = 0;
    n_rst    = 1'b0;
    tx_start = 1'b0;
    tx_data  = '0;

    // Reset held with random inputs: nothing may be accepted.
    repeat (6) drive(1'(($urandom) & 1), D'($urandom));
    @(negedge clk);
    n_rst    = 1'b1;
    tx_start = 1'b0;
    idle_cycles(4);

    // Single 0xA5 frame, a rejected 0xFF request mid-frame, then a
    // back-to-back 0x00 frame in the tx_done cycle.
    drive(1'b1, 8'hA5);
    s1 = cyc;
    idle_cycles(49);
    drive(1'b1, 8'hFF);
    idle_cycles(L - 50);
    drive(1'b1, 8'h00);
    s2 = cyc;
    if (s2 != s1 + L + 1) begin
      fails++;
      $display("FAIL back_to_back_timing: got cycle %0d, expected %0d", s2, s1 + L + 1);
    end
    checks++;
    idle_cycles(44);

    // Mid-frame reset: line returns high without waiting for a clock.
    @(negedge clk);
    n_rst    = 1'b0;
    tx_start = 1'b0;
    q.delete();
    #1;
    check("async_reset_line", serial_out, 1'b1);
    check("async_reset_busy", tx_busy, 1'b0);
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    idle_cycles(2);
    drive(1'b1, 8'h3C);
    idle_cycles(L + 5);

    // Randomized requests, many landing while busy.
    repeat (3000) drive(1'($urandom_range(0, 15) == 0), D'($urandom));
    idle_cycles(L + 5);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule : tb_uart_tx
`default_nettype wire
